// File: rtl/bit_serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package bit_serial_subtractor_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    // 2'b11 is unused; the FSM treats it as illegal and falls back to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/bit_serial_subtractor_full_subtractor.sv
// One-bit full subtractor built from gate primitives, structured like the 1-bit full adder.
module full_subtractor_gatelevel (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    logic a_eq_b;
    logic a_n;
    logic gen_borrow;
    logic prop_borrow;

    // a ^ b ^ bin == xnor(xnor(a, b), bin)
    xnor u_xnor_ab   (a_eq_b, a, b);
    xnor u_xnor_diff (diff, a_eq_b, bin);

    not  u_not_a     (a_n, a);
    and  u_and_gen   (gen_borrow, a_n, b);
    and  u_and_prop  (prop_borrow, a_eq_b, bin);
    or   u_or_bout   (bout, gen_borrow, prop_borrow);

endmodule

// File: rtl/bit_serial_subtractor.sv
// Multi-cycle a - b - bin, one bit per clock LSB first, with start/ready/done handshake.
module bit_serial_subtractor
    import bit_serial_subtractor_pkg::*;
#(
    parameter  int unsigned WIDTH = DEFAULT_WIDTH,
    localparam int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             cell_diff;
    logic             cell_bout;

    full_subtractor_gatelevel u_cell (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .bin  (br_q),
        .diff (cell_diff),
        .bout (cell_bout)
    );

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                res_d  = {cell_diff, res_q[WIDTH-1:1]};
                br_d   = cell_bout;
                if (cnt_q == LAST_BIT) begin
                    // Counter holds at WIDTH-1 instead of wrapping on the final bit.
                    diff_d  = {cell_diff, res_q[WIDTH-1:1]};
                    bout_d  = cell_bout;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = (state_d == RUN);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign diff  = diff_q;
    assign bout  = bout_q;

endmodule

// File: doc/bit_serial_subtractor.md
Name: bit_serial_subtractor

Overview:
- Multi-cycle subtractor that computes diff = a - b - bin over WIDTH-bit operands, one bit per clock, LSB first.
- It is the inverse-operation counterpart of the team's gate-level 1-bit full adder: one full-subtractor cell plus a borrow flip-flop, reused over WIDTH cycles.
- Sits in the arithmetic datapath wherever area matters more than latency.
- Uses a start/ready/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits; must be >= 2.
- CNT_W, $clog2(WIDTH), width of the internal bit counter; derived, not overridden.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only while ready=1.
- a  input  WIDTH  minuend; sampled on the accepting edge.
- b  input  WIDTH  subtrahend; sampled on the accepting edge.
- bin  input  1  borrow-in; sampled on the accepting edge.
- ready  output  1  high in IDLE only.
- busy  output  1  high in RUN only.
- done  output  1  single-cycle pulse; result is valid.
- diff  output  WIDTH  result; held until the next accepted start.
- bout  output  1  final borrow-out; 1 iff a < b + bin.

Behaviour:
- Reset (async, rst=1) forces:
  - state=IDLE, ready=1, busy=0, done=0, diff=0, bout=0, counter=0.
  - Internal shift registers and the borrow flop are cleared.
  - Reset takes effect immediately, including mid-RUN; the operation in flight is discarded, with no partial result and no done.
- FSM states and transitions:
  - IDLE: start=1 at an edge loads a and b into shift registers, borrow flop <= bin, counter <= 0, and moves to RUN. With start=0 it stays in IDLE.
  - RUN: each edge processes bit 0 of the shift registers:
    - d = a0 ^ b0 ^ br
    - br_next = (~a0 & b0) | (~(a0 ^ b0) & br)
    - d shifts into the MSB of the result shift register; the operand registers shift right; borrow <= br_next; counter++.
    - On the edge where counter == WIDTH-1: diff <= final result shift-register value, bout <= br_next, next state DONE.
  - DONE: done=1 for exactly this one cycle, then unconditionally IDLE. start is ignored in DONE.
- Latency:
  - Accept edge E0, then RUN edges E1..EWIDTH.
  - done is high in the cycle after EWIDTH, i.e. WIDTH cycles after acceptance.
  - Throughput is one operation per WIDTH+2 cycles: the accept cycle, WIDTH RUN cycles, and DONE.
- start, a, b and bin are don't-care outside the IDLE accepting edge. Changing them during RUN must not affect the result.
- diff and bout change only on the final RUN edge and on reset. They are stable in DONE and in the subsequent IDLE cycles.
- Wrap-around: the result is modulo 2^WIDTH and bout flags underflow. {bout, diff} equals the (WIDTH+1)-bit two's-complement value of a - b - bin.
- Counter never exceeds WIDTH-1. It is only meaningful in RUN.
- Exactly one of ready, busy and done is high in every cycle after reset.

Decomposition:
- Shared package/include file holds:
  - state encoding localparams: IDLE=2'b00, RUN=2'b01, DONE=2'b10; 2'b11 is illegal and recovers to IDLE.
  - the default WIDTH constant.
- One sub-module, full_subtractor_gatelevel (ports a, b, bin, diff, bout):
  - built structurally from the team's existing xnor/not/and/or gate primitives, mirroring the full adder structure.
  - instantiated once as the per-bit cell; the FSM, counter and shift registers live in bit_serial_subtractor.

Test Plan:
- Reset: assert rst mid-RUN (counter=3) -> same cycle ready=1, busy=0, done=0, diff=0, bout=0; no done pulse afterward.
- WIDTH=8, a=0x5A, b=0x23, bin=0 -> done exactly 8 cycles after the accept edge, diff=0x37, bout=0.
- Underflow: a=0x10, b=0x20, bin=0 -> diff=0xF0, bout=1. a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
- Borrow chain: a=0xFF, b=0xFF, bin=1 -> diff=0xFF, bout=1. a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0.
- Handshake: hold start=1 continuously and change a/b every cycle during RUN and DONE. Required:
  - only the operands present at the IDLE edge are used.
  - the next accept occurs in the IDLE cycle immediately after done.
  - diff holds from done until the next result.
- Random: 1000 operations with random a, b, bin and random idle gaps. {bout, diff} matches the model ({1'b0,a} - b - bin) mod 2^(WIDTH+1). Check the one-hot ready/busy/done invariant every cycle.
